// File: rtl/hi_lo_seq_multiplier_if.sv
// Operand/result handshake bundle for hi_lo_seq_multiplier.
// The master side issues operand pairs and consumes products; the slave is the multiplier.
interface hi_lo_seq_multiplier_if #(
   parameter int WIDTH = 16
);
   logic             io_in_valid;
   logic             io_in_ready;
   logic [WIDTH-1:0] io_A;
   logic [WIDTH-1:0] io_B;
   logic             io_signed;
   logic             io_out_valid;
   logic             io_out_ready;
   logic [WIDTH-1:0] io_Hi;
   logic [WIDTH-1:0] io_Lo;

   modport master (
      output io_in_valid, io_A, io_B, io_signed, io_out_ready,
      input  io_in_ready, io_out_valid, io_Hi, io_Lo
   );

   modport slave (
      input  io_in_valid, io_A, io_B, io_signed, io_out_ready,
      output io_in_ready, io_out_valid, io_Hi, io_Lo
   );
endinterface

// File: rtl/hi_lo_seq_multiplier.sv
// Iterative shift-add WIDTH x WIDTH multiplier with Hi/Lo product halves and ready/valid on both sides.
// Define HILO_SIGNED_EN to honour io_signed (two's-complement operands); otherwise all operands are unsigned.
//
// state | meaning
// IDLE  | ready for an operand pair (io_in_ready=1)
// BUSY  | WIDTH shift-add iterations
// FIX   | one cycle: optional sign correction, product latched to Hi/Lo
// DONE  | product presented (io_out_valid=1) until io_out_ready
module hi_lo_seq_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   hi_lo_seq_multiplier_if.slave bus
);
   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;

   logic [WIDTH-1:0]     a_mag_d;
   logic [WIDTH-1:0]     b_mag_d;
   logic [WIDTH-1:0]     addend_d;
   logic [WIDTH:0]       sum_d;
   logic [2*WIDTH-1:0]   acc_step_d;
   logic [2*WIDTH-1:0]   acc_fix_d;

`ifdef HILO_SIGNED_EN
   logic neg_d;
   logic neg_q;

   // Magnitudes fit in WIDTH unsigned bits, so -MIN is representable and MIN*MIN is exact.
   always_comb begin
      a_mag_d = bus.io_A;
      b_mag_d = bus.io_B;
      neg_d   = 1'b0;
      if (bus.io_signed) begin
         if (bus.io_A[WIDTH-1]) a_mag_d = -bus.io_A;
         if (bus.io_B[WIDTH-1]) b_mag_d = -bus.io_B;
         neg_d = bus.io_A[WIDTH-1] ^ bus.io_B[WIDTH-1];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                    neg_q <= 1'b0;
      else if (state_q == IDLE && bus.io_in_valid)   neg_q <= neg_d;
   end

   assign acc_fix_d = neg_q ? -acc_q : acc_q;
`else
   logic unused_signed;

   assign a_mag_d       = bus.io_A;
   assign b_mag_d       = bus.io_B;
   assign acc_fix_d     = acc_q;
   assign unused_signed = bus.io_signed;
`endif

   // Add into the upper half with carry kept, then shift the whole accumulator right.
   always_comb begin
      addend_d   = mplier_q[0] ? mcand_q : '0;
      sum_d      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend_d};
      acc_step_d = {sum_d, acc_q[WIDTH-1:1]};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.io_in_valid) begin
                  mcand_q  <= a_mag_d;
                  mplier_q <= b_mag_d;
                  acc_q    <= '0;
                  cnt_q    <= CNT_INIT;
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               acc_q    <= acc_step_d;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= acc_fix_d[2*WIDTH-1:WIDTH];
               lo_q    <= acc_fix_d[WIDTH-1:0];
               state_q <= DONE;
            end
            DONE: begin
               if (bus.io_out_ready) begin
                  hi_q    <= '0;
                  lo_q    <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.io_in_ready  = (state_q == IDLE);
   assign bus.io_out_valid = (state_q == DONE);
   assign bus.io_Hi        = hi_q;
   assign bus.io_Lo        = lo_q;
endmodule
